// File: rtl/hpsfpga_spi_pkg.sv
// hpsfpga_spi_pkg: register map, status/control bit indices and FSM encodings for the SPI shifter.
package hpsfpga_spi_pkg;
  localparam logic [1:0] ADDR_RXDATA  = 2'd0;
  localparam logic [1:0] ADDR_TXDATA  = 2'd1;
  localparam logic [1:0] ADDR_STATUS  = 2'd2;
  localparam logic [1:0] ADDR_CONTROL = 2'd3;
  localparam int STAT_BUSY     = 0;
  localparam int STAT_RX_VALID = 1;
  localparam int STAT_OVERRUN  = 2;
  localparam int CTRL_CS_FORCE = 0;
  localparam int CTRL_IRQ_EN   = 1;
  localparam int FRAME_BITS    = 8;
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_SHIFT = 2'd2,
    S_HOLD  = 2'd3
  } state_t;
endpackage

// File: rtl/hpsfpga_spi_clkgen.sv
// hpsfpga_spi_clkgen: SCLK half-period counter; phase_end pulses on the last cycle of each half-period.
module hpsfpga_spi_clkgen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  output logic phase_end
);
  localparam logic [7:0] LAST = 8'(CLK_DIV - 1);
  logic [7:0] cnt;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) cnt <= '0;
    else cnt <= (clear || phase_end) ? 8'd0 : cnt + 8'd1;
  assign phase_end = cnt == LAST;
endmodule

// File: rtl/hpsfpga_spi_shifter.sv
// hpsfpga_spi_shifter: Avalon-MM SPI master (mode 0, MSB first, 8-bit frames).
// Define HPSFPGA_SPI_MISO_SYNC_EN to pass spi_miso through a 2-flop synchronizer.
module hpsfpga_spi_shifter
  import hpsfpga_spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        chipselect,
  input  logic [1:0]  address,
  input  logic        read_n,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        irq,
  output logic        spi_sclk,
  output logic        spi_mosi,
  input  logic        spi_miso,
  output logic        spi_cs_n
);
  state_t state, state_nx;
  logic phase_end, wr, rd, start, done, busy, last_bit, miso_in;
  logic cs_force, cs_force_nx, irq_en, rx_valid, overrun, unused_wdata;
  logic [7:0] shreg, rx_byte;
  logic [2:0] bit_cnt;
  logic [31:0] status, control;
  assign wr = chipselect & ~write_n;
  assign rd = chipselect & ~read_n;
  assign busy = state != S_IDLE;
  assign start = wr && address == ADDR_TXDATA && !busy;
  assign done = state == S_HOLD && phase_end;
  assign last_bit = bit_cnt == 3'(FRAME_BITS - 1);
  assign cs_force_nx = (wr && address == ADDR_CONTROL) ? writedata[CTRL_CS_FORCE] : cs_force;
  assign irq = rx_valid & irq_en;
  assign unused_wdata = ^writedata[31:8];
`ifdef HPSFPGA_SPI_MISO_SYNC_EN
  logic [1:0] miso_sync;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) miso_sync <= '0;
    else miso_sync <= {miso_sync[0], spi_miso};
  assign miso_in = miso_sync[1];
`else
  assign miso_in = spi_miso;
`endif
  hpsfpga_spi_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (start),
    .phase_end (phase_end)
  );
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= S_IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  state_nx = start ? S_SETUP : S_IDLE;
      S_SETUP: state_nx = phase_end ? S_SHIFT : S_SETUP;
      S_SHIFT: state_nx = (phase_end && spi_sclk && last_bit) ? S_HOLD : S_SHIFT;
      S_HOLD:  state_nx = phase_end ? S_IDLE : S_HOLD;
      default: state_nx = S_IDLE;
    endcase
  end
  always_comb begin
    status = '0;
    status[STAT_BUSY] = busy;
    status[STAT_RX_VALID] = rx_valid;
    status[STAT_OVERRUN] = overrun;
    control = '0;
    control[CTRL_CS_FORCE] = cs_force;
    control[CTRL_IRQ_EN] = irq_en;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      shreg    <= '0;
      bit_cnt  <= '0;
      spi_sclk <= 1'b0;
      spi_mosi <= 1'b0;
      spi_cs_n <= 1'b1;
      rx_byte  <= '0;
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
      cs_force <= 1'b0;
      irq_en   <= 1'b0;
      readdata <= '0;
    end else begin
      if (start) begin
        shreg    <= writedata[7:0];
        spi_mosi <= writedata[7];
        bit_cnt  <= '0;
      end else if (state == S_SHIFT && phase_end) begin
        spi_sclk <= ~spi_sclk;
        if (spi_sclk) begin
          shreg   <= {shreg[6:0], miso_in};
          bit_cnt <= bit_cnt + 3'd1;
          if (!last_bit) spi_mosi <= shreg[6];
        end
      end
      // cs_n tracks the incoming cs_force value so a CONTROL write takes effect on the next cycle
      spi_cs_n <= (start || (busy && !done)) ? 1'b0 : ~cs_force_nx;
      if (done) rx_byte <= shreg;
      rx_valid <= done | (rx_valid & ~(rd && address == ADDR_RXDATA));
      overrun  <= (done & rx_valid) | (overrun & ~(wr && address == ADDR_STATUS && writedata[STAT_OVERRUN]));
      cs_force <= cs_force_nx;
      if (wr && address == ADDR_CONTROL) irq_en <= writedata[CTRL_IRQ_EN];
      readdata <= address == ADDR_RXDATA ? {24'd0, rx_byte} :
                  address == ADDR_STATUS ? status :
                  address == ADDR_CONTROL ? control : 32'd0;
    end
endmodule

// File: tb/tb_hpsfpga_spi_shifter.sv
// tb_hpsfpga_spi_shifter: register-table and directed frame sequences for the SPI shifter, CLK_DIV=4.
module tb_hpsfpga_spi_shifter;
  import hpsfpga_spi_pkg::*;
  logic clk = 1'b0, reset_n = 1'b0, chipselect = 1'b0, read_n = 1'b1, write_n = 1'b1;
  logic [1:0] address = 2'd0;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic irq, spi_sclk, spi_mosi, spi_miso, spi_cs_n;
  logic [7:0] slv_byte = 8'd0;
  logic [7:0] mosi_cap = 8'd0;
  logic [31:0] fall_cnt = 32'd0;
  int rise_cnt = 0, cs_hi = 0, tests = 0, failed = 0, r0 = 0;
  bit mon = 1'b0;
  logic [2:0] fidx;
  logic [31:0] d;
  typedef struct {
    logic        wr;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;
  vec_t vt[10];

  hpsfpga_spi_shifter #(.CLK_DIV(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .chipselect (chipselect),
    .address    (address),
    .read_n     (read_n),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq        (irq),
    .spi_sclk   (spi_sclk),
    .spi_mosi   (spi_mosi),
    .spi_miso   (spi_miso),
    .spi_cs_n   (spi_cs_n)
  );

  always #5 clk = ~clk;

  // Mode-0 slave: presents bit 7 first, advances on each falling sclk.
  assign fidx = fall_cnt[2:0];
  assign spi_miso = slv_byte[~fidx];
  always @(posedge spi_sclk) begin
    mosi_cap <= {mosi_cap[6:0], spi_mosi};
    rise_cnt <= rise_cnt + 1;
  end
  always @(negedge spi_sclk) fall_cnt <= fall_cnt + 32'd1;
  always @(posedge clk) if (mon && spi_cs_n) cs_hi <= cs_hi + 1;

  task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic check1(input string name, input logic got, input logic exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [31:0] wd);
    @(negedge clk);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = wd;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_rd(input logic [1:0] a, output logic [31:0] rd);
    @(negedge clk);
    chipselect = 1'b1; read_n = 1'b0; address = a;
    @(negedge clk);
    rd = readdata;
    chipselect = 1'b0; read_n = 1'b1;
  endtask

  task automatic run_frame(input logic [7:0] tx, input logic [7:0] rx);
    slv_byte = rx;
    bus_wr(ADDR_TXDATA, {24'd0, tx});
    wait_cyc(74);
  endtask

  initial begin
    vt[0] = '{1'b0, ADDR_RXDATA,  32'd0,          32'd0};
    vt[1] = '{1'b0, ADDR_TXDATA,  32'd0,          32'd0};
    vt[2] = '{1'b0, ADDR_STATUS,  32'd0,          32'd0};
    vt[3] = '{1'b0, ADDR_CONTROL, 32'd0,          32'd0};
    vt[4] = '{1'b1, ADDR_CONTROL, 32'hFFFF_FFFF,  32'd0};
    vt[5] = '{1'b0, ADDR_CONTROL, 32'd0,          32'd3};
    vt[6] = '{1'b0, ADDR_TXDATA,  32'd0,          32'd0};
    vt[7] = '{1'b1, ADDR_STATUS,  32'hFFFF_FFFF,  32'd0};
    vt[8] = '{1'b1, ADDR_CONTROL, 32'd0,          32'd0};
    vt[9] = '{1'b0, ADDR_CONTROL, 32'd0,          32'd0};

    wait_cyc(3);
    check32("reset readdata", readdata, 32'd0);
    check1("reset irq", irq, 1'b0);
    check1("reset sclk", spi_sclk, 1'b0);
    check1("reset mosi", spi_mosi, 1'b0);
    check1("reset cs_n", spi_cs_n, 1'b1);
    reset_n = 1'b1;
    wait_cyc(2);

    for (int i = 0; i < 10; i++) begin
      if (vt[i].wr) bus_wr(vt[i].addr, vt[i].wdata);
      else begin
        bus_rd(vt[i].addr, d);
        check32($sformatf("vec%0d", i), d, vt[i].exp);
      end
    end
    check1("idle cs_n after table", spi_cs_n, 1'b1);

    // Basic frame: 0xA5 out, 0x3C in, completion timing
    slv_byte = 8'h3C;
    r0 = rise_cnt;
    bus_wr(ADDR_TXDATA, 32'hA5);
    check1("cycle1 cs_n", spi_cs_n, 1'b0);
    check1("cycle1 mosi", spi_mosi, 1'b1);
    check1("cycle1 sclk", spi_sclk, 1'b0);
    address = ADDR_STATUS;
    wait_cyc(71);
    check1("cycle72 cs_n", spi_cs_n, 1'b0);
    check32("cycle71 status", readdata, 32'h1);
    wait_cyc(1);
    check1("cycle73 cs_n", spi_cs_n, 1'b1);
    check32("cycle72 status", readdata, 32'h1);
    wait_cyc(1);
    check32("cycle73 status", readdata, 32'h2);
    check32("mosi bits A5", {24'd0, mosi_cap}, 32'hA5);
    check32("sclk rises", rise_cnt - r0, 32'd8);
    bus_rd(ADDR_RXDATA, d);
    check32("rx 3C", d, 32'h3C);
    bus_rd(ADDR_STATUS, d);
    check32("status after read", d, 32'h0);

    // Overrun from two unread frames, then clear
    run_frame(8'h00, 8'h11);
    run_frame(8'h00, 8'h22);
    bus_rd(ADDR_STATUS, d);
    check32("overrun status", d, 32'h6);
    bus_wr(ADDR_STATUS, 32'h4);
    bus_rd(ADDR_STATUS, d);
    check32("overrun cleared", d, 32'h2);
    bus_rd(ADDR_RXDATA, d);
    check32("rx overwritten 22", d, 32'h22);
    bus_rd(ADDR_STATUS, d);
    check32("status idle", d, 32'h0);

    // RXDATA read in the completion cycle: old byte returned, rx_valid stays set
    run_frame(8'h00, 8'h77);
    slv_byte = 8'h99;
    bus_wr(ADDR_TXDATA, 32'h0);
    wait_cyc(70);
    bus_rd(ADDR_RXDATA, d);
    check32("race old byte", d, 32'h77);
    bus_rd(ADDR_STATUS, d);
    check32("race status", d, 32'h6);
    bus_rd(ADDR_RXDATA, d);
    check32("race new byte", d, 32'h99);
    bus_wr(ADDR_STATUS, 32'h4);

    // TXDATA write while busy is ignored
    slv_byte = 8'h5A;
    r0 = rise_cnt;
    bus_wr(ADDR_TXDATA, 32'hC3);
    wait_cyc(20);
    bus_wr(ADDR_TXDATA, 32'h55);
    wait_cyc(150);
    check32("busy write mosi", {24'd0, mosi_cap}, 32'hC3);
    check32("busy write rises", rise_cnt - r0, 32'd8);
    bus_rd(ADDR_RXDATA, d);
    check32("busy write rx", d, 32'h5A);

    // Interrupt enable/disable
    bus_wr(ADDR_CONTROL, 32'h2);
    check1("irq before frame", irq, 1'b0);
    run_frame(8'h00, 8'h12);
    check1("irq raised", irq, 1'b1);
    bus_rd(ADDR_RXDATA, d);
    check32("irq rx", d, 32'h12);
    check1("irq cleared", irq, 1'b0);
    bus_wr(ADDR_CONTROL, 32'h0);
    run_frame(8'h00, 8'h34);
    check1("irq disabled", irq, 1'b0);
    bus_rd(ADDR_STATUS, d);
    check32("irq disabled status", d, 32'h2);
    bus_rd(ADDR_RXDATA, d);
    check32("irq disabled rx", d, 32'h34);

    // cs_force across back-to-back frames
    bus_wr(ADDR_CONTROL, 32'h1);
    check1("cs_force low", spi_cs_n, 1'b0);
    mon = 1'b1;
    slv_byte = 8'hF0;
    bus_wr(ADDR_TXDATA, 32'h0F);
    wait_cyc(72);
    slv_byte = 8'h81;
    bus_wr(ADDR_TXDATA, 32'hF0);
    wait_cyc(74);
    mon = 1'b0;
    check32("cs_force held", cs_hi, 32'd0);
    check32("cs_force mosi", {24'd0, mosi_cap}, 32'hF0);
    bus_wr(ADDR_CONTROL, 32'h0);
    check1("cs_force released", spi_cs_n, 1'b1);
    bus_rd(ADDR_STATUS, d);
    check32("cs_force status", d, 32'h6);
    bus_wr(ADDR_STATUS, 32'h4);
    bus_rd(ADDR_RXDATA, d);
    check32("cs_force rx", d, 32'h81);

    // Asynchronous reset during bit 3 high phase
    slv_byte = 8'hFF;
    bus_wr(ADDR_TXDATA, 32'hAA);
    address = ADDR_STATUS;
    wait_cyc(41);
    check1("bit3 sclk high", spi_sclk, 1'b1);
    check32("bit3 busy", readdata, 32'h1);
    #2 reset_n = 1'b0;
    #1;
    check1("rst sclk", spi_sclk, 1'b0);
    check1("rst cs_n", spi_cs_n, 1'b1);
    check1("rst mosi", spi_mosi, 1'b0);
    check32("rst readdata", readdata, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    bus_rd(ADDR_STATUS, d);
    check32("post rst status", d, 32'h0);
    bus_rd(ADDR_RXDATA, d);
    check32("post rst rx", d, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
